mu0_control: RTL

- Moore/Mealy control FSM that sequences the MU0 datapath through alternating fetch and execute cycles.
- Decodes the 4-bit opcode F and the N/Z flags into the datapath strobes: X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En and M.
- Generates memory Rd/Wr strobes, stalls on a memory ready handshake, supports run/pause, halts on STP, and keeps a retired-instruction counter.
- Sits beside the datapath inside the MU0 top level, between the datapath and memory.

---
 rtl/mu0_control.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mu0_control.sv
// mu0_control: control sequencer for the MU0 datapath.
// Alternates FETCH and EXECUTE phases, decodes the opcode and the Acc flags
// into datapath selects/enables, drives the memory Rd/Wr strobes, stalls on
// Mem_Ready, pauses at fetch when Run is low, halts on STP and counts
// retired instructions.
//
// Ports:
//   Clk, Reset        - rising-edge clock, asynchronous active-high reset
//   F                 - opcode (IR[15:12])
//   N, Z              - Acc negative / zero flags
//   Mem_Ready         - memory access completes this cycle
//   Run               - allows the next fetch to start
//   X_sel, Y_sel      - ALU operand selects (X: 0 Acc / 1 PC, Y: 0 Din / 1 IR)
//   Addr_sel          - memory address select (0 PC / 1 IR[11:0])
//   PC_En, IR_En, Acc_En - register load enables
//   M                 - ALU function (00 Y, 01 X+Y, 10 X+1, 11 X-Y)
//   Rd, Wr            - memory strobes
//   Halted            - high while stopped by STP
//   Instr_Count       - instructions retired since reset (wraps)
module mu0_control #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       F,
  input  logic             N,
  input  logic             Z,
  input  logic             Mem_Ready,
  input  logic             Run,
  output logic             X_sel,
  output logic             Y_sel,
  output logic             Addr_sel,
  output logic             PC_En,
  output logic             IR_En,
  output logic             Acc_En,
  output logic [1:0]       M,
  output logic             Rd,
  output logic             Wr,
  output logic             Halted,
  output logic [CNT_W-1:0] Instr_Count
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;
  state_t state_next;
  logic   retire;
  logic   mem_op;

  // Opcodes 0-3 (LDA, STA, ADD, SUB) touch memory in the execute phase
  assign mem_op = (F[3:2] == 2'b00);

  // State register and retired-instruction counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= FETCH;
      Instr_Count <= '0;
    end else begin
      state <= state_next;
      if (retire) begin
        Instr_Count <= Instr_Count + CNT_ONE;
      end
    end
  end

  // Next-state logic; an instruction retires on the edge that leaves EXECUTE
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        if (Run && Mem_Ready) begin
          state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        if (!mem_op || Mem_Ready) begin
          retire     = 1'b1;
          state_next = (F == 4'h7) ? HALT : FETCH;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Output decode; register enables of memory phases are gated by Mem_Ready
  // so a stalled access holds address/strobes without updating anything
  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    M        = 2'b00;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Halted   = 1'b0;
    if (!Reset) begin
      case (state)
        FETCH: begin
          if (Run) begin
            Addr_sel = 1'b0;
            Rd       = 1'b1;
            X_sel    = 1'b1;
            M        = 2'b10;
            IR_En    = Mem_Ready;
            PC_En    = Mem_Ready;
          end
        end
        EXECUTE: begin
          case (F)
            4'h0: begin
              Addr_sel = 1'b1;
              Rd       = 1'b1;
              M        = 2'b00;
              Acc_En   = Mem_Ready;
            end
            4'h1: begin
              Addr_sel = 1'b1;
              Wr       = 1'b1;
            end
            4'h2, 4'h3: begin
              Addr_sel = 1'b1;
              Rd       = 1'b1;
              M        = F[0] ? 2'b11 : 2'b01;
              Acc_En   = Mem_Ready;
            end
            4'h4: begin
              Y_sel = 1'b1;
              PC_En = 1'b1;
            end
            4'h5: begin
              Y_sel = 1'b1;
              PC_En = ~N;
            end
            4'h6: begin
              Y_sel = 1'b1;
              PC_En = ~Z;
            end
            default: begin
            end
          endcase
        end
        HALT: begin
          Halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
